// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the multiplexed seven-segment display:
//               segment pattern constants, hex-to-segment table and the scan
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments off (bit 0 = segment a ... bit 6 = segment g).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Scan scheduler states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Full hex decode; A-F rendered as letters (A b C d E F).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational hex nibble to seven-segment pattern decoder
//               (active-high segments a..g).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup; shared by every multiplexed digit.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan scheduler sharing one seven-segment
//               decoder among NUM_DIGITS digits. Takes a per-frame snapshot of
//               the packed hex value, lights one digit at a time and inserts an
//               optional all-off interval between digits.
// Options     : SEG7_SCAN_LZB_EN - leading-zero blanking of digits 1..N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1000,
    parameter int SHOW_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int IW         = $clog2(NUM_DIGITS);
    localparam int TW         = $clog2(TICK_DIV);
    localparam int PH_MAX     = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int PW         = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BLANK_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;
    localparam int VW         = 4 * NUM_DIGITS;

    scan_state_t         state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [TW-1:0]       presc, presc_nxt;
    logic [PW-1:0]       phase_cnt, phase_nxt;
    logic [VW-1:0]       shadow, shadow_nxt;
    logic                tick;
    logic                phase_end;
    logic                phase_restart;
    logic                snap;

    logic [6:0]          seg_nxt;
    logic [NUM_DIGITS-1:0] dig_sel_nxt;
    logic                frame_start_nxt;

    logic [3:0]          cur_nibble;
    logic [6:0]          dec_seg;
    logic [NUM_DIGITS-1:0] lzb_mask;

    // Next digit index, wrapping after the most significant digit.
    function automatic logic [IW-1:0] idx_advance(input logic [IW-1:0] cur);
        logic [IW-1:0] nxt;
        if (cur == IW'(NUM_DIGITS - 1)) begin
            nxt = '0;
        end else begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

    assign tick = (presc == TW'(TICK_DIV - 1));

    // State, counters, snapshot and output registers; rst_n aborts any scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            presc       <= '0;
            phase_cnt   <= '0;
            shadow      <= '0;
            seg_out     <= SEG_BLANK;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            presc       <= presc_nxt;
            phase_cnt   <= phase_nxt;
            shadow      <= shadow_nxt;
            seg_out     <= seg_nxt;
            dig_sel     <= dig_sel_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    // Next-state logic: phase sequencing, digit index, prescaler and snapshot.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        phase_end = 1'b0;

        case (state)
            SHOW:    phase_end = tick && (phase_cnt == PW'(SHOW_TICKS - 1));
            BLANK:   phase_end = tick && (phase_cnt == PW'(BLANK_LAST));
            default: phase_end = 1'b0;
        endcase

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SHOW;
                    idx_nxt   = '0;
                end
            end
            SHOW: begin
                if (phase_end) begin
                    if (BLANK_TICKS > 0) begin
                        state_nxt = BLANK;
                    end else begin
                        idx_nxt = idx_advance(idx);
                    end
                end
            end
            BLANK: begin
                if (phase_end) begin
                    state_nxt = SHOW;
                    idx_nxt   = idx_advance(idx);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase

        // Disable wins over everything and takes effect on the next edge.
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end

        // Any state change or phase completion starts a fresh, exact-length phase.
        phase_restart = (state_nxt != state) || phase_end;

        if ((state_nxt == IDLE) || phase_restart || tick) begin
            presc_nxt = '0;
        end else begin
            presc_nxt = presc + 1'b1;
        end

        if (phase_restart || (state_nxt == IDLE)) begin
            phase_nxt = '0;
        end else if (tick) begin
            phase_nxt = phase_cnt + 1'b1;
        end else begin
            phase_nxt = phase_cnt;
        end

        // A frame begins whenever digit 0 is (re)entered; capture the value then.
        snap       = phase_restart && (state_nxt == SHOW) && (idx_nxt == '0);
        shadow_nxt = snap ? value : shadow;
    end

    // The decoder sees the nibble that will be on display after this edge, so
    // the registered segments and digit select always change together.
    assign cur_nibble = shadow_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_SCAN_LZB_EN
    // Digit i>0 is blanked when it and every more significant nibble are zero.
    assign lzb_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign lzb_mask[gi] = (shadow_nxt[VW-1:4*gi] == '0);
    end
`else
    assign lzb_mask = '0;
`endif

    // Output decode: only SHOW lights a digit; IDLE and BLANK are all-off.
    always_comb begin
        dig_sel_nxt     = '0;
        seg_nxt         = SEG_BLANK;
        frame_start_nxt = snap;
        if (state_nxt == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_sel_nxt[i] = (idx_nxt == IW'(i));
            end
            seg_nxt = lzb_mask[idx_nxt] ? SEG_BLANK : dec_seg;
        end
    end

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl. Two instances (with and
//               without blanking) run on shared stimulus and are compared each
//               cycle against a frame-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int ST = 2;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;

    logic [6:0]  seg_b1, seg_b0;
    logic [3:0]  dig_b1, dig_b0;
    logic        fs_b1,  fs_b0;

    int total;
    int bad;
    bit checking;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SHOW_TICKS(ST), .BLANK_TICKS(1)) dut_b1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .value       (value),
        .seg_out     (seg_b1),
        .dig_sel     (dig_b1),
        .frame_start (fs_b1)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SHOW_TICKS(ST), .BLANK_TICKS(0)) dut_b0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .value       (value),
        .seg_out     (seg_b0),
        .dig_sel     (dig_b0),
        .frame_start (fs_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the frame timeline, per blanking variant.
    bit          m_act [2];
    int          m_t   [2];
    logic [15:0] m_sh  [2];

    function automatic int period(input int b);
        return ND * (ST + b) * TD;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || !enable) begin
                m_act[k] <= 1'b0;
                m_t[k]   <= 0;
            end else if (!m_act[k]) begin
                m_act[k] <= 1'b1;
                m_t[k]   <= 0;
                m_sh[k]  <= value;
            end else if (m_t[k] == period(k) - 1) begin
                m_t[k]   <= 0;
                m_sh[k]  <= value;
            end else begin
                m_t[k]   <= m_t[k] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs of the variant with b blanking ticks.
    task automatic expect_out(input int k, output logic [3:0] d, output logic [6:0] s,
                              output logic f);
        int          slot_len, slot, off;
        logic [15:0] upper;
        bit          lit;
        slot_len = (ST + k) * TD;
        slot     = m_t[k] / slot_len;
        off      = m_t[k] % slot_len;
        lit      = m_act[k] && (off < ST * TD);
        upper    = m_sh[k] >> (4 * slot);
        d = lit ? 4'(1 << slot) : 4'h0;
        s = lit ? seg_tab[upper[3:0]] : 7'h00;
`ifdef SEG7_SCAN_LZB_EN
        if (lit && slot > 0 && upper == 16'h0) s = 7'h00;
`endif
        f = m_act[k] && (m_t[k] == 0);
    endtask

    // Continuous cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        logic [3:0] d;
        logic [6:0] s;
        logic       f;
        if (checking) begin
            expect_out(1, d, s, f);
            check_eq("dig_b1", {28'h0, dig_b1}, {28'h0, d});
            check_eq("seg_b1", {25'h0, seg_b1}, {25'h0, s});
            check_eq("fs_b1",  {31'h0, fs_b1},  {31'h0, f});
            expect_out(0, d, s, f);
            check_eq("dig_b0", {28'h0, dig_b0}, {28'h0, d});
            check_eq("seg_b0", {25'h0, seg_b0}, {25'h0, s});
            check_eq("fs_b0",  {31'h0, fs_b0},  {31'h0, f});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        total    = 0;
        bad      = 0;
        checking = 1'b0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        value    = 16'h1234;

        // Reset held two cycles with enable high: everything dark.
        cycles(2);
        check_eq("rst_dig", {28'h0, dig_b1}, 32'h0);
        check_eq("rst_seg", {25'h0, seg_b1}, 32'h0);
        check_eq("rst_fs",  {31'h0, fs_b1},  32'h0);
        checking = 1'b1;

        // Scan of 1234, then swap the value while digit 2 is lit.
        rst_n = 1'b1;
        cycles(1);
        check_eq("first_dig", {28'h0, dig_b1}, 32'h1);
        check_eq("first_seg", {25'h0, seg_b1}, 32'h66);
        check_eq("first_fs",  {31'h0, fs_b1},  32'h1);
        n = 0;
        while (dig_b1 != 4'b0100 && n < 100) begin
            cycles(1);
            n++;
        end
        check_eq("wait_d2", {31'h0, n < 100}, 32'h1);
        value = 16'hABCD;
        cycles(110);

        // Disable during digit 1, then re-enable.
        n = 0;
        while (dig_b1 != 4'b0010 && n < 100) begin
            cycles(1);
            n++;
        end
        check_eq("wait_d1", {31'h0, n < 100}, 32'h1);
        enable = 1'b0;
        cycles(1);
        check_eq("dis_dig", {28'h0, dig_b1}, 32'h0);
        check_eq("dis_seg", {25'h0, seg_b1}, 32'h0);
        cycles(3);
        enable = 1'b1;
        cycles(1);
        check_eq("reen_dig", {28'h0, dig_b1}, 32'h1);
        check_eq("reen_fs",  {31'h0, fs_b1},  32'h1);
        cycles(60);

        // Leading-zero patterns.
        value = 16'h0050;
        cycles(100);
        value = 16'h0000;
        cycles(100);

        // Randomized value changes, disables and resets.
        for (int it = 0; it < 40; it++) begin
            value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            cycles($urandom_range(1, 120));
            case ($urandom_range(0, 5))
                0: begin
                    enable = 1'b0;
                    cycles($urandom_range(1, 5));
                    enable = 1'b1;
                end
                1: begin
                    rst_n = 1'b0;
                    cycles($urandom_range(1, 3));
                    rst_n = 1'b1;
                end
                default: ;
            endcase
        end
        cycles(50);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
